// File: rtl/dom_data_rx.sv
// Destination-domain receiver for the req/ack data crossing: synchronizes req_i,
// captures the held source word, hands it to a valid/ready consumer and returns ack.
module dom_data_rx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              req_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ack_o,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              err_o,
  output logic [CNT_W-1:0]  xfer_cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    ACK  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   req_s;
  logic                   ack_q, ack_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  assign req_s = sync_q[SYNC_STAGES-1];

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= IDLE;
      sync_q  <= {SYNC_STAGES{1'b0}};
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= {DATA_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake FSM: data_i is only sampled once req_s proves it has settled.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], req_i};
    state_d = state_q;
    ack_d   = ack_q;
    valid_d = valid_q;
    err_d   = err_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          data_d  = data_i;
          valid_d = 1'b1;
          state_d = HOLD;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        // A withdrawn request is flagged, but the captured word is still delivered.
        if (!req_s) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (ready_i) begin
          valid_d = 1'b0;
          ack_d   = 1'b1;
          cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_d = ACK;
        end else begin
          state_d = HOLD;
        end
      end
      ACK: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = ACK;
        end
      end
      default: begin
        ack_d   = 1'b0;
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign ack_o      = ack_q;
  assign valid_o    = valid_q;
  assign err_o      = err_q;
  assign data_o     = data_q;
  assign xfer_cnt_o = cnt_q;

endmodule

// File: tb/tb_dom_data_rx.sv
// Directed bench for dom_data_rx: vector table plus hand sequences for wrap and reset.
module tb_dom_data_rx;

  logic        clk_i = 1'b0;
  logic        resetn_i = 1'b0;
  logic        req_i = 1'b0;
  logic [7:0]  data_i = 8'h00;
  logic        ready_i = 1'b0;
  logic        ack_o, valid_o, err_o;
  logic [7:0]  data_o;
  logic [15:0] xfer_cnt_o;
  logic        ack4, valid4, err4;
  logic [7:0]  data4;
  logic [3:0]  cnt4;

  int vec_cnt = 0;
  int miscompares = 0;

  typedef struct {
    logic        req;
    logic [7:0]  data;
    logic        ready;
    logic        exp_ack;
    logic        exp_valid;
    logic [7:0]  exp_data;
    logic        exp_err;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  dom_data_rx dut (
    .clk_i(clk_i), .resetn_i(resetn_i), .req_i(req_i), .data_i(data_i),
    .ack_o(ack_o), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .err_o(err_o), .xfer_cnt_o(xfer_cnt_o)
  );

  dom_data_rx #(.CNT_W(4)) dut4 (
    .clk_i(clk_i), .resetn_i(resetn_i), .req_i(req_i), .data_i(data_i),
    .ack_o(ack4), .data_o(data4), .valid_o(valid4), .ready_i(ready_i),
    .err_o(err4), .xfer_cnt_o(cnt4)
  );

  always #5 clk_i = ~clk_i;

  function automatic void add(logic r, logic [7:0] d, logic rdy, logic a, logic v,
                              logic [7:0] ed, logic e, logic [15:0] c);
    vec_t t;
    t.req = r; t.data = d; t.ready = rdy;
    t.exp_ack = a; t.exp_valid = v; t.exp_data = ed; t.exp_err = e; t.exp_cnt = c;
    vecs.push_back(t);
  endfunction

  task automatic check(string name, logic a, logic v, logic [7:0] d, logic e, logic [15:0] c);
    logic [15:0] cc;
    cc = c;
    vec_cnt++;
    if (ack_o !== a || valid_o !== v || data_o !== d || err_o !== e ||
        xfer_cnt_o !== c || cnt4 !== cc[3:0]) begin
      miscompares++;
      $display("FAIL %s: got ack=%b valid=%b data=%h err=%b cnt=%0d cnt4=%0d, want ack=%b valid=%b data=%h err=%b cnt=%0d cnt4=%0d",
               name, ack_o, valid_o, data_o, err_o, xfer_cnt_o, cnt4, a, v, d, e, c, cc[3:0]);
    end
  endtask

  task automatic wait_valid(string name);
    int n;
    n = 0;
    while (valid_o !== 1'b1 && n < 20) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (valid_o !== 1'b1) begin
      vec_cnt++;
      miscompares++;
      $display("FAIL %s: valid_o timeout, got valid=%b want 1", name, valid_o);
    end
  endtask

  task automatic wait_ack_low(string name);
    int n;
    n = 0;
    while (ack_o !== 1'b0 && n < 20) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (ack_o !== 1'b0) begin
      vec_cnt++;
      miscompares++;
      $display("FAIL %s: ack_o timeout, got ack=%b want 0", name, ack_o);
    end
  endtask

  task automatic do_reset();
    req_i = 1'b0; data_i = 8'h00; ready_i = 1'b0;
    resetn_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("reset", 1'b0, 1'b0, 8'h00, 1'b0, 16'd0);
    resetn_i = 1'b1;
  endtask

  initial begin
    // single transfer, ready already high before capture
    add(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0);
    add(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0);
    add(1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 16'd0);
    add(1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 16'd1);
    add(1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 16'd1);
    add(1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 16'd1);
    add(1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 16'd1);
    // backpressure for 10 cycles
    add(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 16'd1);
    add(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 16'd1);
    add(1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 16'd1);
    for (int i = 0; i < 10; i++) add(1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 16'd1);
    add(1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 16'd2);
    // data_i changes while in ACK: no recapture
    add(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 16'd2);
    add(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 16'd2);
    add(1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 16'd2);
    add(1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 16'd2);
    add(1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 16'd2);
    add(1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 16'd2);
    // early withdrawal in HOLD
    add(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 16'd2);
    add(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 16'd2);
    add(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 16'd2);
    add(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 16'd2);
    add(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 16'd2);
    add(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 16'd2);
    add(1'b0, 8'h5A, 1'b1, 1'b1, 1'b0, 8'h5A, 1'b1, 16'd3);
    add(1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b1, 16'd3);
    add(1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b1, 16'd3);

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      req_i = vecs[i].req; data_i = vecs[i].data; ready_i = vecs[i].ready;
      @(posedge clk_i); #1;
      check($sformatf("vec%0d", i), vecs[i].exp_ack, vecs[i].exp_valid,
            vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_cnt);
    end

    // 17 transfers: the 4-bit counter wraps to 1, the 16-bit one reads 17
    do_reset();
    for (int k = 0; k < 17; k++) begin
      req_i = 1'b1; data_i = 8'(k); ready_i = 1'b1;
      wait_valid($sformatf("wrap%0d", k));
      check($sformatf("wrap%0d_data", k), 1'b0, 1'b1, 8'(k), 1'b0, 16'(k));
      @(posedge clk_i); #1;
      check($sformatf("wrap%0d_ack", k), 1'b1, 1'b0, 8'(k), 1'b0, 16'(k + 1));
      req_i = 1'b0; ready_i = 1'b0;
      wait_ack_low($sformatf("wrap%0d", k));
    end

    // reset asserted mid-HOLD with req_i still high
    req_i = 1'b1; data_i = 8'h77; ready_i = 1'b0;
    wait_valid("rst_hold");
    check("rst_hold_pre", 1'b0, 1'b1, 8'h77, 1'b0, 16'd17);
    #2 resetn_i = 1'b0;
    #1 check("rst_async", 1'b0, 1'b0, 8'h00, 1'b0, 16'd0);
    repeat (2) @(posedge clk_i);
    #1 resetn_i = 1'b1;
    @(posedge clk_i); #1;
    check("rst_rel1", 1'b0, 1'b0, 8'h00, 1'b0, 16'd0);
    @(posedge clk_i); #1;
    check("rst_rel2", 1'b0, 1'b0, 8'h00, 1'b0, 16'd0);
    @(posedge clk_i); #1;
    check("rst_rel3", 1'b0, 1'b1, 8'h77, 1'b0, 16'd0);
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    check("rst_ack", 1'b1, 1'b0, 8'h77, 1'b0, 16'd1);
    req_i = 1'b0; ready_i = 1'b0;
    wait_ack_low("rst_release");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
